// File: rtl/prog_sequencer.sv
// Run controller that walks the benchmark programs through one single-cycle core:
// reset the core, load the start PC, release it, time the run, and report.
module prog_sequencer #(
  parameter int PC_W  = 8,
  parameter logic [PC_W-1:0] START0 = 8'd0,
  parameter logic [PC_W-1:0] START1 = 8'd25,
  parameter logic [PC_W-1:0] START2 = 8'd44,
  parameter int CNT_W = 16,
  parameter logic [CNT_W-1:0] TIMEOUT = 16'hFFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             single,
  input  logic [1:0]       prog_sel,
  input  logic             done_in,
  output logic             core_rst,
  output logic             pc_load,
  output logic [PC_W-1:0]  start_addr,
  output logic             busy,
  output logic [1:0]       prog_idx,
  output logic [CNT_W-1:0] cycles,
  output logic             cycles_vld,
  output logic             all_done,
  output logic             err
);

  typedef enum logic [2:0] {IDLE, LOAD, RELEASE, RUN, REPORT} state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   counter;
  logic [CNT_W-1:0]   cnt_inc;
  logic               single_q;
  logic               go_ok;
  logic               last_prog;

  function automatic logic [PC_W-1:0] start_of(input logic [1:0] idx);
    case (idx)
      2'd1:    start_of = START1;
      2'd2:    start_of = START2;
      default: start_of = START0;
    endcase
  endfunction

  assign cnt_inc   = counter + 1'b1;
  assign go_ok     = go && !(single && prog_sel == 2'd3);
  // err can only be set mid-sequence by a timeout, since go clears it.
  assign last_prog = single_q || (prog_idx == 2'd2) || err;

  always_comb begin
    state_next = state;
    core_rst   = 1'b1;
    pc_load    = 1'b0;
    busy       = (state != IDLE);
    cycles_vld = 1'b0;
    all_done   = 1'b0;
    case (state)
      IDLE:    if (go_ok) state_next = LOAD;
      LOAD: begin
        pc_load    = 1'b1;
        state_next = RELEASE;
      end
      RELEASE: begin
        core_rst   = 1'b0;
        state_next = RUN;
      end
      RUN: begin
        core_rst = 1'b0;
        if (done_in || cnt_inc == TIMEOUT) state_next = REPORT;
      end
      REPORT: begin
        cycles_vld = 1'b1;
        all_done   = last_prog;
        state_next = last_prog ? IDLE : LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      start_addr <= START0;
      prog_idx   <= 2'd0;
      cycles     <= '0;
      err        <= 1'b0;
      counter    <= '0;
      single_q   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (go && !go_ok) begin
            err <= 1'b1;
          end else if (go_ok) begin
            err        <= 1'b0;
            single_q   <= single;
            prog_idx   <= single ? prog_sel : 2'd0;
            start_addr <= start_of(single ? prog_sel : 2'd0);
          end
        end
        LOAD: counter <= '0;
        RUN: begin
          if (counter != '1) counter <= cnt_inc;
          // done_in wins over a timeout landing on the same cycle
          if (done_in) begin
            cycles <= cnt_inc;
          end else if (cnt_inc == TIMEOUT) begin
            err    <= 1'b1;
            cycles <= TIMEOUT;
          end
        end
        REPORT: begin
          if (!last_prog) begin
            prog_idx   <= prog_idx + 2'd1;
            start_addr <= start_of(prog_idx + 2'd1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: directed scenarios plus randomized
// sequences checked against a per-program plan model (TIMEOUT shortened to 20).
module tb_prog_sequencer;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        go = 1'b0;
  logic        single = 1'b0;
  logic [1:0]  prog_sel = 2'd0;
  logic        done_in = 1'b0;
  logic        core_rst, pc_load, busy, cycles_vld, all_done, err;
  logic [7:0]  start_addr;
  logic [1:0]  prog_idx;
  logic [15:0] cycles;

  int tests = 0;
  int fails = 0;
  int start_tab [3] = '{0, 25, 44};

  prog_sequencer #(.TIMEOUT(16'd20)) dut (
    .clk(clk), .reset(reset), .go(go), .single(single), .prog_sel(prog_sel),
    .done_in(done_in), .core_rst(core_rst), .pc_load(pc_load),
    .start_addr(start_addr), .busy(busy), .prog_idx(prog_idx),
    .cycles(cycles), .cycles_vld(cycles_vld), .all_done(all_done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at the negedge where the program is expected to be in its load cycle.
  task automatic applyStimulus(input int idx, input int n, input bit is_last, output bit timed_out);
    int eff;
    timed_out = (n > TMO);
    eff = timed_out ? TMO : n;
    checkOutput("load_pc_load", pc_load, 1);
    checkOutput("load_start_addr", start_addr, start_tab[idx]);
    checkOutput("load_prog_idx", prog_idx, idx);
    checkOutput("load_core_rst", core_rst, 1);
    checkOutput("load_busy", busy, 1);
    checkOutput("load_err", err, 0);
    checkOutput("load_cycles_vld", cycles_vld, 0);
    go = 1'b0;
    single = 1'($urandom);
    prog_sel = 2'($urandom);
    done_in = 1'($urandom);
    tick();
    checkOutput("release_pc_load", pc_load, 0);
    checkOutput("release_core_rst", core_rst, 0);
    checkOutput("release_start_addr", start_addr, start_tab[idx]);
    done_in = 1'($urandom);
    tick();
    for (int k = 1; k <= eff; k++) begin
      checkOutput("run_core_rst", core_rst, 0);
      done_in = (k == n);
      if (k < eff) tick();
    end
    tick();
    done_in = 1'b0;
    checkOutput("report_vld", cycles_vld, 1);
    checkOutput("report_cycles", cycles, eff);
    checkOutput("report_all_done", all_done, is_last || timed_out);
    checkOutput("report_err", err, timed_out);
    checkOutput("report_core_rst", core_rst, 1);
    tick();
  endtask

  task automatic runSequence(input bit sgl, input int sel, input int n0, input int n1, input int n2);
    int plan[$];
    int ns[3];
    int last_idx;
    bit to;
    ns = '{n0, n1, n2};
    if (sgl) plan = '{sel};
    else     plan = '{0, 1, 2};
    last_idx = 0;
    go = 1'b1;
    single = sgl;
    prog_sel = 2'(sel);
    tick();
    foreach (plan[i]) begin
      applyStimulus(plan[i], ns[plan[i]], i == plan.size() - 1, to);
      last_idx = plan[i];
      if (to) break;
    end
    checkOutput("end_busy", busy, 0);
    checkOutput("end_all_done", all_done, 0);
    checkOutput("end_prog_idx", prog_idx, last_idx);
    checkOutput("end_core_rst", core_rst, 1);
  endtask

  initial begin
    bit to;
    go = 1'b1;
    tick();
    tick();
    checkOutput("rst_core_rst", core_rst, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_pc_load", pc_load, 0);
    checkOutput("rst_start_addr", start_addr, 0);
    checkOutput("rst_prog_idx", prog_idx, 0);
    checkOutput("rst_cycles", cycles, 0);
    checkOutput("rst_cycles_vld", cycles_vld, 0);
    checkOutput("rst_all_done", all_done, 0);
    checkOutput("rst_err", err, 0);
    go = 1'b0;
    reset = 1'b1;
    tick();

    runSequence(1'b0, 0, 5, 7, 9);
    tick();
    runSequence(1'b1, 1, 0, 3, 0);

    // illegal program select, then a legal go clears err
    go = 1'b1;
    single = 1'b1;
    prog_sel = 2'd3;
    tick();
    go = 1'b0;
    checkOutput("illegal_err", err, 1);
    checkOutput("illegal_busy", busy, 0);
    checkOutput("illegal_pc_load", pc_load, 0);
    tick();
    checkOutput("illegal_err_sticky", err, 1);
    checkOutput("illegal_busy_hold", busy, 0);
    runSequence(1'b1, 2, 0, 0, 4);

    // timeout on program 0 aborts the sequence
    runSequence(1'b0, 0, 30, 5, 5);
    tick();
    checkOutput("timeout_no_reload", pc_load, 0);
    checkOutput("timeout_err_sticky", err, 1);

    // reset in the middle of program 1
    go = 1'b1;
    single = 1'b0;
    tick();
    applyStimulus(0, 4, 1'b0, to);
    checkOutput("mid_load_addr", start_addr, 25);
    tick();
    tick();
    tick();
    tick();
    checkOutput("mid_running", busy, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_prog_idx", prog_idx, 0);
    checkOutput("mid_rst_err", err, 0);
    checkOutput("mid_rst_start_addr", start_addr, 0);
    checkOutput("mid_rst_core_rst", core_rst, 1);
    tick();
    done_in = 1'b1;
    tick();
    done_in = 1'b0;
    checkOutput("idle_done_busy", busy, 0);
    checkOutput("idle_done_vld", cycles_vld, 0);
    checkOutput("idle_done_cycles", cycles, 0);
    runSequence(1'b0, 0, 2, 2, 2);

    // randomized sequences, run lengths straddling the timeout
    for (int r = 0; r < 12; r++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        done_in = 1'($urandom);
        tick();
      end
      done_in = 1'b0;
      runSequence(1'($urandom), $urandom_range(0, 2), $urandom_range(1, 23),
                  $urandom_range(1, 23), $urandom_range(1, 23));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
Top-level run controller for the single-cycle core. It sequences the three benchmark programs (product, string match, closest pair) through one core. For each program it holds the core in reset, drives the program's start address into the PC load path, releases the core, and measures cycles until the core raises done. This replaces toggling the PC reset by hand and gives the bench per-program cycle counts plus a hang watchdog.

Parameters:
PC_W, 8, width of program counter / start address
START0, 0, start PC of program 0 (product)
START1, 25, start PC of program 1 (string match)
START2, 44, start PC of program 2 (closest pair)
CNT_W, 16, width of cycle counters
TIMEOUT, 16'hFFFF, max run cycles per program before abort

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-low (reset==0 resets block)
go  in  1  start request, sampled only in IDLE
single  in  1  1 = run only prog_sel; 0 = run programs 0,1,2 in order
prog_sel  in  2  program index for single mode (3 is illegal)
done_in  in  1  core halt/done flag
core_rst  out  1  active-high reset to core datapath
pc_load  out  1  one-cycle strobe: core PC <= start_addr
start_addr  out  PC_W  start address for current program
busy  out  1  high whenever state != IDLE
prog_idx  out  2  program currently loaded/running
cycles  out  CNT_W  latched run length of last finished program
cycles_vld  out  1  one-cycle strobe when cycles updates
all_done  out  1  one-cycle strobe at end of sequence
err  out  1  sticky: timeout or illegal prog_sel; cleared by reset or next accepted go

Behaviour:
- Reset (reset==0 at clk edge): state=IDLE, core_rst=1, pc_load=0, start_addr=START0, busy=0, prog_idx=0, cycles=0, cycles_vld=0, all_done=0, err=0, run counter=0. Reset overrides every state, including mid-RUN.
- States: IDLE, LOAD, RELEASE, RUN, REPORT.
- IDLE: core_rst=1. If go=1:
  - single=1 and prog_sel==3: set err, stay in IDLE.
  - Otherwise clear err, set prog_idx (prog_sel if single, else 0), go to LOAD.
- LOAD (1 cycle): core_rst=1, pc_load=1, start_addr=START[prog_idx], counter cleared. Next state: RELEASE.
- RELEASE (1 cycle): core_rst=0, pc_load=0. Next state: RUN. First core instruction executes at the RELEASE edge.
- RUN: core_rst=0; counter increments by 1 each cycle and saturates at all-ones.
  - done_in=1: cycles <= counter+1 (number of RUN cycles including this one), next state REPORT.
  - Else if counter+1 == TIMEOUT: err=1, cycles <= TIMEOUT, next state REPORT.
  - done_in has priority over timeout on the same cycle.
- REPORT (1 cycle): cycles_vld=1, core_rst=1.
  - If single=1 (latched at go), or prog_idx==2, or err was set by timeout: all_done=1, next state IDLE.
  - Otherwise prog_idx += 1, next state LOAD.
- Timeout aborts the rest of the sequence.
- start_addr holds its last value outside LOAD.
- single and prog_sel are latched at go; changes during busy are ignored. go while busy is ignored.
- done_in is ignored outside RUN.
- Latency: go to first pc_load is 1 cycle. A program with N run cycles reports cycles=N. Full 3-program sequence overhead is 3 cycles per program.

Test Plan:
- Reset held low for 2 cycles with go=1 -> IDLE, core_rst=1, busy=0, all outputs at reset values.
- single=0, go pulse; bench raises done_in after 5, 7, 9 RUN cycles -> pc_load with start_addr 0, 25, 44 in order; cycles=5, 7, 9 each with cycles_vld; all_done once; busy drops the next cycle.
- single=1, prog_sel=1, done after 3 cycles -> exactly one pc_load with start_addr=25, cycles=3, all_done; prog_idx=1.
- single=1, prog_sel=3 -> err=1, busy stays 0, no pc_load. A following legal go clears err.
- TIMEOUT=20, done_in never asserted -> err=1, cycles=20, all_done after program 0, programs 1 and 2 never loaded.
- reset driven low mid-RUN of program 1, then high -> IDLE with prog_idx=0, err=0. Next go restarts at START0. done_in pulsed in IDLE -> no response.
